lbp_stream: RTL and testbench
=============================

# lbp_stream

Parametrised successor to the fixed 128x128 LBP engine. It computes 3x3 local-binary-pattern codes over a `2^XW` x `2^YW` grey image and writes them to the LBP result memory. A sliding 3x3 window register cuts reads from 9 to 3 per pixel after the first pixel of each row. It adds a programmable comparison threshold and an optional border-fill mode. It sits between the grey-image ROM and the LBP result RAM, using the same request/ready/valid/finish handshake as the current engine.

## Interface
- `XW`, default 7: column address width; image width `W = 2^XW`.
- `YW`, default 7: row address width; image height `H = 2^YW`.
- `PW`, default 8: grey pixel width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `gray_ready` in 1: image available. Level; sampled only in IDLE.
- `thr` in PW: comparison threshold. Sampled into a register on leaving IDLE.
- `border_mode` in 1: 0 = interior only; 1 = also write 0 to every border pixel. Sampled on leaving IDLE.
- `gray_addr` out YW+XW: read address `{y,x}`.
- `gray_req` out 1: read request.
- `gray_data` in PW: read data. Combinational: valid in the same cycle as `gray_addr`.
- `lbp_addr` out YW+XW: write address `{y,x}`.
- `lbp_valid` out 1: write strobe, one cycle per pixel.
- `lbp_data` out 8: LBP code.
- `finish` out 1: one-cycle pulse after the last write.
- `busy` out 1: high in every state except IDLE.

## Operation
**States**
- IDLE → LOAD when `gray_ready`=1.
- LOAD: 9 reads, counter 0..8, then WRITE.
- SHIFT: 3 reads, counter 0..2, then WRITE.
- WRITE: one cycle.
  - Next is SHIFT if `x < W-2`.
  - Otherwise, if `y < H-2`, next is LOAD with `y+1`, `x=1`.
  - Otherwise next is BORDER (`border_mode`=1) or FINISH.
- BORDER: one write per cycle, then FINISH.
- FINISH → IDLE.

**Reads**
- LOAD reads columns `x-1`, `x`, `x+1`. Within each column the order is rows `y-1`, `y`, `y+1`.
- SHIFT first moves window columns left (c0←c1, c1←c2), then reads the new column `x+1` (rows `y-1`, `y`, `y+1`) into c2.
- `gray_req`=1 only in LOAD and SHIFT.
- `gray_data` is captured into the window on the clock edge that ends the read cycle.

**Code computation**
- Bit map:
  - bit0 = (y-1,x-1), bit1 = (y-1,x), bit2 = (y-1,x+1)
  - bit3 = (y,x-1), bit4 = (y,x+1)
  - bit5 = (y+1,x-1), bit6 = (y+1,x), bit7 = (y+1,x+1)
- A bit is set iff `neighbour >= centre + thr`, compared at PW+1 bits with no wrap. If `centre + thr > 2^PW - 1`, the bit is always 0.
- The code is registered on entry to WRITE.

**Writes**
- Interior addresses go in raster order from (1,1) to (H-2,W-2); `x`, `y` advance in WRITE.
- BORDER order, all with `lbp_data`=0:
  - row 0, x = 0..W-1;
  - rows 1..H-2, each as x=0 then x=W-1;
  - row H-1, x = 0..W-1.
- Border write count is `2W + 2(H-2)`.

**Boundary and control behaviour**
- `thr` and `border_mode` changes mid-frame are ignored.
- `gray_ready` is ignored outside IDLE.
- If `gray_ready` is still high in IDLE after FINISH, a new frame starts.
- `reset_n` low at any time clears all registers and returns to IDLE.
  - Outputs go to reset values immediately.
  - No partial write follows.

## Timing
- Reset values: `gray_addr`=0, `gray_req`=0, `lbp_addr`=0, `lbp_valid`=0, `lbp_data`=0, `finish`=0, `busy`=0.
- `lbp_valid` is high only in WRITE and BORDER. `lbp_addr` and `lbp_data` are stable during those cycles.
- Per row: 10 cycles for the first pixel and 4 cycles for each further pixel, i.e. `10 + 4(W-3)` cycles.
- Frame, measured from the first LOAD cycle to `finish`:
  - `(H-2)(10 + 4(W-3))` cycles;
  - plus `2W + 2(H-2)` cycles if `border_mode`=1;
  - `finish` is the cycle after that.
- Default 128x128: 64260 cycles for interior; 508 more with border.
- `gray_ready` high at edge n puts the block in LOAD at cycle n+1.

## Test plan
- XW=YW=3, constant image 50, `thr`=0, `border_mode`=0 → 36 writes of 0xFF at (1,1)..(6,6) in raster order. `finish` 180 cycles after the first LOAD cycle, then `busy`=0.
- 8x8 ramp with pixel `= x + 8y`, `thr`=0 → every code is 0xF0. Check the `gray_req` count is 6 × (9 + 5×3) = 144.
- Same ramp with `thr`=2 → every code is 0xE0 (right neighbour `centre+1` fails the threshold).
- Constant 255, `thr`=1 → all codes 0x00 (saturation path, no wrap).
- 8x8, `border_mode`=1 → 36 interior writes, then 28 border writes of 0 in the specified order. All 64 addresses are written exactly once.
- Pull `reset_n` low during the 10th interior write → all outputs 0 in the same cycle and state IDLE. Release with `gray_ready`=1 → a full, correct frame restarting at (1,1).

Source files
------------

// File: rtl/lbp_stream.sv
// Streaming 3x3 local-binary-pattern engine: reads a 2^YW x 2^XW grey image through a
// sliding window and writes one 8-bit code per interior pixel, optionally zero-filling the border.
module lbp_stream #(
  parameter int XW = 7,
  parameter int YW = 7,
  parameter int PW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               gray_ready,
  input  logic [PW-1:0]      thr,
  input  logic               border_mode,
  output logic [YW+XW-1:0]   gray_addr,
  output logic               gray_req,
  input  logic [PW-1:0]      gray_data,
  output logic [YW+XW-1:0]   lbp_addr,
  output logic               lbp_valid,
  output logic [7:0]         lbp_data,
  output logic               finish,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WRITE,
    S_BORDER,
    S_FINISH
  } state_t;

  localparam logic [XW-1:0] X_ALL  = {XW{1'b1}};
  localparam logic [YW-1:0] Y_ALL  = {YW{1'b1}};
  localparam logic [XW-1:0] X_STOP = X_ALL - XW'(1);
  localparam logic [YW-1:0] Y_STOP = Y_ALL - YW'(1);

  state_t              r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [1:0]          r_col;
  logic [1:0]          r_row;
  logic [PW-1:0]       r_thr;
  logic                r_border;
  logic [PW-1:0]       r_win [0:2][0:2];
  logic [YW+XW-1:0]    r_gray_addr;
  logic                r_gray_req;
  logic [YW+XW-1:0]    r_lbp_addr;
  logic                r_lbp_valid;
  logic [7:0]          r_lbp_data;
  logic                r_finish;
  logic                r_busy;

  logic [PW-1:0]       w_win [0:2][0:2];
  logic [PW:0]         w_sum;
  logic [7:0]          w_code;
  logic                w_last_read;
  logic [1:0]          w_nrow;
  logic [1:0]          w_ncol;
  logic [YW-1:0]       w_rd_y;
  logic [XW-1:0]       w_rd_x;
  logic [XW-1:0]       w_bx;
  logic [YW-1:0]       w_by;
  logic                w_bdone;

  assign gray_addr = r_gray_addr;
  assign gray_req  = r_gray_req;
  assign lbp_addr  = r_lbp_addr;
  assign lbp_valid = r_lbp_valid;
  assign lbp_data  = r_lbp_data;
  assign finish    = r_finish;
  assign busy      = r_busy;

  // Window as it will look after this cycle's read lands, so the code can be formed on the last read.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        w_win[c][r] = (2'(c) == r_col && 2'(r) == r_row) ? gray_data : r_win[c][r];
      end
    end
  end

  // Threshold sum is one bit wider so a saturating centre+thr never wraps and simply clears every bit.
  always_comb begin
    w_sum     = {1'b0, w_win[1][1]} + {1'b0, r_thr};
    w_code    = '0;
    w_code[0] = ({1'b0, w_win[0][0]} >= w_sum);
    w_code[1] = ({1'b0, w_win[1][0]} >= w_sum);
    w_code[2] = ({1'b0, w_win[2][0]} >= w_sum);
    w_code[3] = ({1'b0, w_win[0][1]} >= w_sum);
    w_code[4] = ({1'b0, w_win[2][1]} >= w_sum);
    w_code[5] = ({1'b0, w_win[0][2]} >= w_sum);
    w_code[6] = ({1'b0, w_win[1][2]} >= w_sum);
    w_code[7] = ({1'b0, w_win[2][2]} >= w_sum);
  end

  assign w_last_read = (r_row == 2'd2) && (r_col == 2'd2);
  assign w_nrow      = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
  assign w_ncol      = (r_row == 2'd2) ? r_col + 2'd1 : r_col;
  assign w_rd_y      = r_y - YW'(1) + YW'(w_nrow);
  assign w_rd_x      = r_x - XW'(1) + XW'(w_ncol);

  // Border walk: full top row, left/right pairs for middle rows, then full bottom row.
  always_comb begin
    w_bx    = r_x;
    w_by    = r_y;
    w_bdone = 1'b0;
    if (r_y == '0 || r_y == Y_ALL) begin
      if (r_x == X_ALL) begin
        if (r_y == Y_ALL) begin
          w_bdone = 1'b1;
        end else begin
          w_by = r_y + YW'(1);
          w_bx = '0;
        end
      end else begin
        w_bx = r_x + XW'(1);
      end
    end else if (r_x == '0) begin
      w_bx = X_ALL;
    end else begin
      w_bx = '0;
      w_by = r_y + YW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_thr       <= '0;
      r_border    <= 1'b0;
      r_gray_addr <= '0;
      r_gray_req  <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_valid <= 1'b0;
      r_lbp_data  <= '0;
      r_finish    <= 1'b0;
      r_busy      <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          r_win[c][r] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (gray_ready) begin
            r_state     <= S_LOAD;
            r_x         <= XW'(1);
            r_y         <= YW'(1);
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_thr       <= thr;
            r_border    <= border_mode;
            r_gray_req  <= 1'b1;
            r_gray_addr <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_LOAD, S_SHIFT: begin
          for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
              r_win[c][r] <= w_win[c][r];
            end
          end
          if (w_last_read) begin
            r_state     <= S_WRITE;
            r_gray_req  <= 1'b0;
            r_gray_addr <= '0;
            r_lbp_valid <= 1'b1;
            r_lbp_addr  <= {r_y, r_x};
            r_lbp_data  <= w_code;
          end else begin
            r_row       <= w_nrow;
            r_col       <= w_ncol;
            r_gray_addr <= {w_rd_y, w_rd_x};
          end
        end
        S_WRITE: begin
          r_lbp_valid <= 1'b0;
          if (r_x < X_STOP) begin
            r_state     <= S_SHIFT;
            r_x         <= r_x + XW'(1);
            r_col       <= 2'd2;
            r_row       <= 2'd0;
            r_gray_req  <= 1'b1;
            r_gray_addr <= {r_y - YW'(1), r_x + XW'(2)};
            for (int r = 0; r < 3; r++) begin
              r_win[0][r] <= r_win[1][r];
              r_win[1][r] <= r_win[2][r];
            end
          end else if (r_y < Y_STOP) begin
            r_state     <= S_LOAD;
            r_y         <= r_y + YW'(1);
            r_x         <= XW'(1);
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_gray_req  <= 1'b1;
            r_gray_addr <= {r_y, XW'(0)};
          end else if (r_border) begin
            r_state     <= S_BORDER;
            r_x         <= '0;
            r_y         <= '0;
            r_lbp_valid <= 1'b1;
            r_lbp_addr  <= '0;
            r_lbp_data  <= '0;
          end else begin
            r_state     <= S_FINISH;
            r_finish    <= 1'b1;
          end
        end
        S_BORDER: begin
          if (w_bdone) begin
            r_state     <= S_FINISH;
            r_lbp_valid <= 1'b0;
            r_finish    <= 1'b1;
          end else begin
            r_x         <= w_bx;
            r_y         <= w_by;
            r_lbp_addr  <= {w_by, w_bx};
          end
        end
        S_FINISH: begin
          r_state  <= S_IDLE;
          r_finish <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream on an 8x8 image: uniform, ramp and saturated images,
// threshold and border modes, and a mid-frame reset followed by a clean restart.
module tb_lbp_stream;

  localparam int XW = 3;
  localparam int YW = 3;
  localparam int PW = 8;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       grayReady = 1'b0;
  logic       borderMode = 1'b0;
  logic [7:0] thrIn = 8'd0;
  logic [5:0] grayAddr;
  logic [5:0] lbpAddr;
  logic       grayReq;
  logic       lbpValid;
  logic       finishOut;
  logic       busyOut;
  logic [7:0] grayData;
  logic [7:0] lbpData;

  logic [7:0] img [0:63];
  logic [5:0] expAddr [0:63];
  logic [7:0] expData [0:63];
  int         expCount;
  int         total = 0;
  int         bad = 0;

  assign grayData = img[grayAddr];

  always #5 clk = ~clk;

  lbp_stream #(.XW(XW), .YW(YW), .PW(PW)) dut (
    .clk        (clk),
    .reset_n    (resetN),
    .gray_ready (grayReady),
    .thr        (thrIn),
    .border_mode(borderMode),
    .gray_addr  (grayAddr),
    .gray_req   (grayReq),
    .gray_data  (grayData),
    .lbp_addr   (lbpAddr),
    .lbp_valid  (lbpValid),
    .lbp_data   (lbpData),
    .finish     (finishOut),
    .busy       (busyOut)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // kind 0: constant 50, 1: ramp x+8y, 2: constant 255
  task automatic setImage(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       img[i] = 8'd50;
        1:       img[i] = 8'(i);
        default: img[i] = 8'd255;
      endcase
    end
  endtask

  task automatic pushExp(input int y, input int x, input logic [7:0] code);
    expAddr[expCount] = 6'(8 * y + x);
    expData[expCount] = code;
    expCount++;
  endtask

  task automatic buildExpected(input logic [7:0] code, input logic withBorder);
    expCount = 0;
    for (int y = 1; y <= 6; y++)
      for (int x = 1; x <= 6; x++)
        pushExp(y, x, code);
    if (withBorder) begin
      for (int x = 0; x < 8; x++) pushExp(0, x, 8'd0);
      for (int y = 1; y <= 6; y++) begin
        pushExp(y, 0, 8'd0);
        pushExp(y, 7, 8'd0);
      end
      for (int x = 0; x < 8; x++) pushExp(7, x, 8'd0);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] t, input logic bm);
    @(negedge clk);
    thrIn = t;
    borderMode = bm;
    grayReady = 1'b1;
    @(posedge clk);
    #1;
    grayReady = 1'b0;
  endtask

  // Called in the first LOAD cycle; walks the frame, scoring writes against the expected list.
  task automatic runFrame(input string tag, input int expFinish, input int abortAt);
    int   cyc = 0;
    int   nw = 0;
    int   nreq = 0;
    int   badw = 0;
    int   firstBad = -1;
    logic done = 1'b0;
    thrIn = ~thrIn;
    borderMode = ~borderMode;
    while (!done && cyc <= 1000) begin
      if (grayReq) nreq++;
      if (lbpValid) begin
        if (nw >= expCount || lbpAddr !== expAddr[nw] || lbpData !== expData[nw]) begin
          if (badw == 0) firstBad = nw;
          badw++;
        end
        nw++;
        if (abortAt != 0 && nw == abortAt) begin
          resetN = 1'b0;
          #1;
          checkOutput({tag, " writes before reset"}, 32'(badw), 32'd0);
          checkOutput({tag, " gray_addr"}, 32'(grayAddr), 32'd0);
          checkOutput({tag, " gray_req"}, 32'(grayReq), 32'd0);
          checkOutput({tag, " lbp_addr"}, 32'(lbpAddr), 32'd0);
          checkOutput({tag, " lbp_valid"}, 32'(lbpValid), 32'd0);
          checkOutput({tag, " lbp_data"}, 32'(lbpData), 32'd0);
          checkOutput({tag, " finish"}, 32'(finishOut), 32'd0);
          checkOutput({tag, " busy"}, 32'(busyOut), 32'd0);
          return;
        end
      end
      if (finishOut) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checkOutput({tag, " finish seen"}, 32'(done), 32'd1);
    checkOutput({tag, " finish cycle"}, 32'(cyc), 32'(expFinish));
    checkOutput({tag, " write count"}, 32'(nw), 32'(expCount));
    checkOutput({tag, " bad writes"}, 32'(badw), 32'd0);
    if (badw != 0) $display("[TB] %s first wrong write index %0d", tag, firstBad);
    checkOutput({tag, " gray_req count"}, 32'(nreq), 32'd144);
    @(posedge clk);
    #1;
    checkOutput({tag, " busy after"}, 32'(busyOut), 32'd0);
    checkOutput({tag, " finish after"}, 32'(finishOut), 32'd0);
    checkOutput({tag, " lbp_valid after"}, 32'(lbpValid), 32'd0);
  endtask

  initial begin
    setImage(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset gray_addr", 32'(grayAddr), 32'd0);
    checkOutput("reset gray_req", 32'(grayReq), 32'd0);
    checkOutput("reset lbp_addr", 32'(lbpAddr), 32'd0);
    checkOutput("reset lbp_valid", 32'(lbpValid), 32'd0);
    checkOutput("reset lbp_data", 32'(lbpData), 32'd0);
    checkOutput("reset finish", 32'(finishOut), 32'd0);
    checkOutput("reset busy", 32'(busyOut), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    buildExpected(8'hFF, 1'b0);
    applyStimulus(8'd0, 1'b0);
    checkOutput("const50 first busy", 32'(busyOut), 32'd1);
    checkOutput("const50 first req", 32'(grayReq), 32'd1);
    checkOutput("const50 first addr", 32'(grayAddr), 32'd0);
    runFrame("const50", 180, 0);

    setImage(1);
    buildExpected(8'hF0, 1'b0);
    applyStimulus(8'd0, 1'b0);
    runFrame("ramp thr0", 180, 0);

    buildExpected(8'hE0, 1'b0);
    applyStimulus(8'd2, 1'b0);
    runFrame("ramp thr2", 180, 0);

    setImage(2);
    buildExpected(8'h00, 1'b0);
    applyStimulus(8'd1, 1'b0);
    runFrame("sat thr1", 180, 0);

    setImage(1);
    buildExpected(8'hF0, 1'b1);
    applyStimulus(8'd0, 1'b1);
    runFrame("ramp border", 208, 0);

    buildExpected(8'hF0, 1'b0);
    applyStimulus(8'd0, 1'b0);
    runFrame("abort", 0, 10);
    thrIn = 8'd0;
    borderMode = 1'b0;
    grayReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held reset busy", 32'(busyOut), 32'd0);
    checkOutput("held reset req", 32'(grayReq), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    grayReady = 1'b0;
    checkOutput("restart req", 32'(grayReq), 32'd1);
    checkOutput("restart addr", 32'(grayAddr), 32'd0);
    runFrame("restart", 180, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
